// File: rtl/mux_slave_fifo.sv
// mux_slave_fifo: consumer of the mux request bus. Each accepted request
// stores (i_sel ? i_b : i_a) into a small FIFO that a sink drains with a
// valid/ready handshake. The last drained result is returned on o_y.
// Optional feature macro: MUX_SLAVE_STATS_EN (counts accepted sel=1 pushes).
module mux_slave_fifo #(
    parameter int DATA_WITH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DATA_WITH-1:0]       i_a,
    input  logic [DATA_WITH-1:0]       i_b,
    input  logic                       i_sel,
    output logic [DATA_WITH-1:0]       o_y,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [DATA_WITH-1:0]       o_res_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [15:0]                o_sel_b_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WITH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [DATA_WITH-1:0] y_reg;

    logic                 push;
    logic                 pop;
    logic [DATA_WITH-1:0] wr_data;

    // Handshake decode; ready/valid depend only on registered occupancy,
    // so a full FIFO never writes through even when the sink pops.
    assign o_ready     = (count_reg != FULL_CNT);
    assign o_res_valid = (count_reg != '0);
    assign push        = i_valid & o_ready;
    assign pop         = o_res_valid & i_res_ready;
    assign wr_data     = i_sel ? i_b : i_a;

    assign o_res_data  = mem[rd_ptr_reg];
    assign o_count     = count_reg;
    assign o_y         = y_reg;

    // Storage array: written on push, no reset needed since occupancy gates use.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, occupancy and the returned result register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            y_reg      <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                y_reg      <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef MUX_SLAVE_STATS_EN
    logic [15:0] sel_b_cnt_reg;

    // Saturating count of accepted requests that selected input b.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_b_cnt_reg <= '0;
        end else if (push && i_sel && (sel_b_cnt_reg != 16'hFFFF)) begin
            sel_b_cnt_reg <= sel_b_cnt_reg + 16'd1;
        end
    end

    assign o_sel_b_cnt = sel_b_cnt_reg;
`else
    assign o_sel_b_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_slave_fifo.sv
// Directed testbench for mux_slave_fifo (DATA_WITH=8, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
`timescale 1ns/1ps
module tb_mux_slave_fifo;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sel;
    logic [7:0]  y;
    logic        valid;
    logic        ready;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [2:0]  count;
    logic [15:0] sel_b_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    mux_slave_fifo #(.DATA_WITH(8), .DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a         (a),
        .i_b         (b),
        .i_sel       (sel),
        .o_y         (y),
        .i_valid     (valid),
        .o_ready     (ready),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_count     (count),
        .o_sel_b_cnt (sel_b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        res_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; sel = 1'b0;
        step();
        total_cnt++;
        if ({count, res_valid, ready, y} !== {3'd0, 1'b0, 1'b1, 8'h00})
            $display("FAIL reset_state: count=%0d res_valid=%b ready=%b y=%h, want 0 0 1 00", count, res_valid, ready, y);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if ({count, res_valid, ready, y, sel_b_cnt} !== {3'd0, 1'b0, 1'b1, 8'h00, 16'h0000})
            $display("FAIL reset_release: count=%0d res_valid=%b ready=%b y=%h cnt=%h, want 0 0 1 00 0000", count, res_valid, ready, y, sel_b_cnt);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_basic_select();
        do_reset();
        valid = 1'b1; a = 8'h11; b = 8'h22; sel = 1'b0;
        step();
        total_cnt++;
        if ({count, res_valid, res_data} !== {3'd1, 1'b1, 8'h11})
            $display("FAIL basic_push1: count=%0d res_valid=%b data=%h, want 1 1 11", count, res_valid, res_data);
        else pass_cnt++;
        a = 8'h33; b = 8'h44; sel = 1'b1;
        step();
        valid = 1'b0;
        step();
        total_cnt++;
        if ({count, res_data, y} !== {3'd2, 8'h11, 8'h00})
            $display("FAIL basic_hold: count=%0d data=%h y=%h, want 2 11 00", count, res_data, y);
        else pass_cnt++;
        res_ready = 1'b1;
        step();
        total_cnt++;
        if ({count, res_data, y} !== {3'd1, 8'h44, 8'h11})
            $display("FAIL basic_pop1: count=%0d data=%h y=%h, want 1 44 11", count, res_data, y);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({count, res_valid, y} !== {3'd0, 1'b0, 8'h44})
            $display("FAIL basic_pop2: count=%0d res_valid=%b y=%h, want 0 0 44", count, res_valid, y);
        else pass_cnt++;
        res_ready = 1'b0;
        step();
        step();
        total_cnt++;
        if (y !== 8'h44)
            $display("FAIL basic_y_hold: y=%h, want 44", y);
        else pass_cnt++;
`ifndef MUX_SLAVE_STATS_EN
        total_cnt++;
        if (sel_b_cnt !== 16'h0000)
            $display("FAIL stats_off: sel_b_cnt=%h, want 0000", sel_b_cnt);
        else pass_cnt++;
`endif
        $display("test_basic_select done");
    endtask

    task automatic test_full();
        logic [7:0] exp_q[$];
        int guard;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            valid = 1'b1; a = 8'(i); b = 8'hEE; sel = 1'b0;
            step();
        end
        total_cnt++;
        if ({count, ready, res_valid} !== {3'd4, 1'b0, 1'b1})
            $display("FAIL full_state: count=%0d ready=%b res_valid=%b, want 4 0 1", count, ready, res_valid);
        else pass_cnt++;
        a = 8'h05;
        step();
        total_cnt++;
        if ({count, res_data} !== {3'd4, 8'h01})
            $display("FAIL full_drop: count=%0d data=%h, want 4 01", count, res_data);
        else pass_cnt++;
        // full with pop and push requested together: pop only
        a = 8'h06; res_ready = 1'b1;
        step();
        valid = 1'b0; res_ready = 1'b0;
        total_cnt++;
        if ({count, y, res_data} !== {3'd3, 8'h01, 8'h02})
            $display("FAIL full_pop: count=%0d y=%h data=%h, want 3 01 02", count, y, res_data);
        else pass_cnt++;
        exp_q = '{8'h02, 8'h03, 8'h04};
        res_ready = 1'b1;
        guard = 0;
        while (res_valid && guard < 10) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL full_drain_extra: data=%h, want no more entries", res_data);
            end else begin
                if (res_data !== exp_q[0])
                    $display("FAIL full_drain: data=%h, want %h", res_data, exp_q[0]);
                else pass_cnt++;
                void'(exp_q.pop_front());
            end
            step();
            guard++;
        end
        res_ready = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0 || count !== 3'd0)
            $display("FAIL full_drain_len: remaining=%0d count=%0d, want 0 0", exp_q.size(), count);
        else pass_cnt++;
        $display("test_full done");
    endtask

    task automatic test_wrap();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1; a = 8'(i); b = 8'hFF; sel = 1'b0;
            step();
            total_cnt++;
            if ({count, res_data} !== {3'd1, 8'(i)})
                $display("FAIL wrap_%0d: count=%0d data=%h, want 1 %h", i, count, res_data, 8'(i));
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (y !== 8'(i - 1))
                    $display("FAIL wrap_y_%0d: y=%h, want %h", i, y, 8'(i - 1));
                else pass_cnt++;
            end
        end
        valid = 1'b0;
        step();
        res_ready = 1'b0;
        total_cnt++;
        if ({count, y} !== {3'd0, 8'h09})
            $display("FAIL wrap_end: count=%0d y=%h, want 0 09", count, y);
        else pass_cnt++;
        $display("test_wrap done");
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; a = 8'hA0 + 8'(i); b = 8'h00; sel = 1'b0;
            step();
        end
        valid = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        valid = 1'b1; a = 8'hA3;
        step();
        valid = 1'b0;
        total_cnt++;
        if ({count, y} !== {3'd3, 8'hA0})
            $display("FAIL mid_pre: count=%0d y=%h, want 3 a0", count, y);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({count, res_valid, ready, y} !== {3'd0, 1'b0, 1'b1, 8'h00})
            $display("FAIL mid_async: count=%0d res_valid=%b ready=%b y=%h, want 0 0 1 00", count, res_valid, ready, y);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({count, res_valid, ready, y} !== {3'd0, 1'b0, 1'b1, 8'h00})
            $display("FAIL mid_next: count=%0d res_valid=%b ready=%b y=%h, want 0 0 1 00", count, res_valid, ready, y);
        else pass_cnt++;
        rst = 1'b0;
        step();
        $display("test_reset_midstream done");
    endtask

`ifdef MUX_SLAVE_STATS_EN
    task automatic test_stats();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; a = 8'h01; b = 8'h02; sel = (i < 5);
            step();
        end
        total_cnt++;
        if (sel_b_cnt !== 16'd5)
            $display("FAIL stats_count: sel_b_cnt=%0d, want 5", sel_b_cnt);
        else pass_cnt++;
        sel = 1'b1;
        for (int i = 0; i < 65530; i++) step();
        total_cnt++;
        if (sel_b_cnt !== 16'hFFFF)
            $display("FAIL stats_reach_max: sel_b_cnt=%h, want ffff", sel_b_cnt);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (sel_b_cnt !== 16'hFFFF)
            $display("FAIL stats_saturate: sel_b_cnt=%h, want ffff", sel_b_cnt);
        else pass_cnt++;
        valid = 1'b0; res_ready = 1'b0;
        do_reset();
        total_cnt++;
        if (sel_b_cnt !== 16'h0000)
            $display("FAIL stats_clear: sel_b_cnt=%h, want 0000", sel_b_cnt);
        else pass_cnt++;
        $display("test_stats done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic_select();
        test_full();
        test_wrap();
        test_reset_midstream();
`ifdef MUX_SLAVE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
